// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver states, idle level and baud divider helper.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return int'(longint'(clk_hz) / (longint'(baud) * longint'(os)));
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-clock tick every DIV clocks, restartable to phase zero.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit, PARITY_ODD and parity_err.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0) begin : g_bad_cfg
    $error("uart_rx_core: unsupported CLK_HZ/BAUD/DATA_BITS/OVERSAMPLE combination");
  end
  logic [1:0]           rx_q;
  logic                 rx_s, tick, restart, mid, last, stop_ok, stop_bad, load;
  rx_state_t            state, state_n;
  logic [OW-1:0]        os_cnt, os_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_n;
`endif
  assign rx_s = rx_q[1];
  assign busy = state != IDLE;
  assign mid  = tick && os_cnt == OW'(OVERSAMPLE / 2 - 1);
  assign last = tick && os_cnt == OW'(OVERSAMPLE - 1);
  assign load = stop_ok && (!data_valid || data_ready);
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );
  always_comb begin
    state_n  = state;
    os_n     = (tick && state != IDLE) ? os_cnt + OW'(1) : os_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    restart  = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n    = par_bad;
`endif
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        os_n    = '0;
        bit_n   = '0;
        restart = 1'b1;
      end
      START: if (mid) begin
        state_n = rx_s ? IDLE : DATA;
        os_n    = '0;
      end
      DATA: if (last) begin
        shift_n = {rx_s, shift[DATA_BITS-1:1]};
        bit_n   = bit_cnt + BW'(1);
        os_n    = '0;
`ifdef UART_RX_PARITY_EN
        state_n = bit_cnt == BW'(DATA_BITS - 1) ? PARITY : DATA;
`else
        state_n = bit_cnt == BW'(DATA_BITS - 1) ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (last) begin
        par_n   = (^shift ^ rx_s) != PARITY_ODD;
        state_n = STOP;
        os_n    = '0;
      end
`endif
      STOP: if (last) begin
        stop_ok  = rx_s;
        stop_bad = !rx_s;
        state_n  = IDLE;
        os_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_q       <= {2{UART_IDLE_LEVEL}};
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_q       <= {rx_q[0], rx};
      state      <= state_n;
      os_cnt     <= os_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      frame_err  <= stop_bad;
      overrun    <= stop_ok && data_valid && !data_ready;
      data       <= load ? shift : data;
      data_valid <= load || (data_valid && !data_ready);
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_n;
      parity_err <= load && par_bad;
`endif
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed table-driven bench for uart_rx_core at 16 clk per bit.
module tb_uart_rx_core;
  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, data_ready = 1'b1;
  logic [7:0] data;
  logic data_valid, frame_err, overrun, busy;
  int total = 0, bad = 0;
  int nv = 0, ndv = 0, nfe = 0, nov = 0, nbusy = 0, nboth = 0;
  logic dv_q = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  int npe = 0;
`endif
  uart_rx_core #(
    .CLK_HZ(16000000), .BAUD(1000000), .DATA_BITS(8), .OVERSAMPLE(16)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .frame_err(frame_err), .overrun(overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (data_valid && !dv_q) nv++;
    if (data_valid) ndv++;
    if (frame_err) nfe++;
    if (overrun) nov++;
    if (busy) nbusy++;
    if (frame_err && overrun) nboth++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) npe++;
`endif
    dv_q = data_valid;
  end
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input bit stop, input bit p);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (PB != 0) begin
      rx = p;
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask
  typedef struct {
    logic [7:0] d;
    bit         stop;
    int         exp_nv;
    logic [7:0] exp_data;
    int         exp_nfe;
    int         exp_busy;
  } vec_t;
  vec_t v[6];
  int b_nv, b_ndv, b_nfe, b_nov, b_busy;
  task automatic snap();
    b_nv = nv; b_ndv = ndv; b_nfe = nfe; b_nov = nov; b_busy = nbusy;
  endtask
  initial begin
    v[0] = '{8'h55, 1'b1, 1, 8'h55, 0, 152};
    v[1] = '{8'hA3, 1'b0, 0, 8'h55, 1, 0};
    v[2] = '{8'h3C, 1'b1, 1, 8'h3C, 0, 152};
    v[3] = '{8'h00, 1'b1, 1, 8'h00, 0, 152};
    v[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0, 152};
    v[5] = '{8'h80, 1'b1, 1, 8'h80, 0, 152};
    repeat (3) @(negedge clk);
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      snap();
      send(v[i].d, v[i].stop, ^v[i].d);
      repeat (30) @(negedge clk);
      check($sformatf("vec%0d_nvalid", i), nv - b_nv, v[i].exp_nv);
      check($sformatf("vec%0d_valid_cycles", i), ndv - b_ndv, v[i].exp_nv);
      check($sformatf("vec%0d_data", i), int'(data), int'(v[i].exp_data));
      check($sformatf("vec%0d_frame_err", i), nfe - b_nfe, v[i].exp_nfe);
      if (v[i].exp_busy != 0)
        check($sformatf("vec%0d_busy_cycles", i), nbusy - b_busy, v[i].exp_busy + PB * BIT);
    end
    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_cycles", nbusy - b_busy, 8);
    check("glitch_nvalid", nv - b_nv, 0);
    check("glitch_frame_err", nfe - b_nfe, 0);
    check("glitch_idle", int'(busy), 0);
    data_ready = 1'b0;
    snap();
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    check("ovr_nvalid", nv - b_nv, 1);
    check("ovr_data", int'(data), 8'h11);
    check("ovr_valid", int'(data_valid), 1);
    check("ovr_count", nov - b_nov, 1);
    check("ovr_frame_err", nfe - b_nfe, 0);
    data_ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", int'(data_valid), 0);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    repeat (4 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mid_busy_before", int'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_valid", int'(data_valid), 0);
    check("rst_mid_data", int'(data), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    snap();
    send(8'h0F, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    check("post_rst_nvalid", nv - b_nv, 1);
    check("post_rst_data", int'(data), 8'h0F);
    check("post_rst_frame_err", nfe - b_nfe, 0);
`ifdef UART_RX_PARITY_EN
    begin
      int b_pe;
      b_pe = npe;
      send(8'h07, 1'b1, 1'b0);
      repeat (30) @(negedge clk);
      check("par_bad_pulse", npe - b_pe, 1);
      check("par_bad_data", int'(data), 8'h07);
      b_pe = npe;
      snap();
      send(8'h07, 1'b1, 1'b1);
      repeat (30) @(negedge clk);
      check("par_ok_pulse", npe - b_pe, 0);
      check("par_ok_nvalid", nv - b_nv, 1);
    end
`endif
    check("frame_err_and_overrun_together", nboth, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised oversampling UART receiver, 8N1 by default. It supersedes the fixed one-bit-per-state receive machine in the uart top level.
- Synchronises the asynchronous rx line and qualifies the start bit.
- Samples each bit at its centre.
- Checks the stop bit and presents received words through a valid/ready holding register with overrun detection.
- Sits between the board RX pin and user logic: a loopback to the transmitter, or LED/character decode.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz
BAUD, 115200, line bit rate
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
OVERSAMPLE, 16, sample ticks per bit (even, >=4)
DIV, CLK_HZ/(BAUD*OVERSAMPLE), localparam clocks per tick; elaboration error if <1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
data  out  DATA_BITS  received word, stable while data_valid=1
data_valid  out  1  holding register full
data_ready  in  1  consumer accepts data when data_valid&data_ready at a clk edge
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: frame completed while holding register still full
busy  out  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset: asynchronous assert; all state returns to defaults.
  - Synchroniser flops = 1; FSM = IDLE; counters = 0.
  - data = 0, data_valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - Reset mid-frame discards the partial word; the first frame after deassert needs a fresh falling edge.
- Synchroniser: 2 flops on rx → rx_s. All decisions use rx_s only.
- Tick generator: counter 0..DIV-1; tick=1 for one clk on wrap. Free-running, restarted to 0 on start detection.
- Tick counter os_cnt: width $clog2(OVERSAMPLE); cleared on every state entry.
- Bit counter bit_cnt: width $clog2(DATA_BITS+1).
- FSM states and transitions:
  - IDLE: busy=0. rx_s==0 → START, clear counters.
  - START: on tick, os_cnt++. At os_cnt==OVERSAMPLE/2-1 sample rx_s.
    - 1 → IDLE (glitch rejected; no flags raised).
    - 0 → DATA, os_cnt=0.
  - DATA: on tick, os_cnt++. At os_cnt==OVERSAMPLE-1: shift rx_s into the MSB of the shift register (LSB-first line order), bit_cnt++.
    - bit_cnt reaches DATA_BITS → PARITY (if enabled) else STOP.
  - PARITY (macro only): sample at os_cnt==OVERSAMPLE-1, latch parity result → STOP.
  - STOP: sample at os_cnt==OVERSAMPLE-1, i.e. mid stop bit.
    - rx_s==0 → frame_err pulse next cycle, word discarded.
    - rx_s==1 → deliver word.
    - Either case → IDLE in the same cycle, so a back-to-back start bit half a bit later is caught.
- Delivery, at the clk edge after the stop sample:
  - data_valid==0: data←shift, data_valid←1.
  - data_valid==1 and data_ready==1 in that cycle: accept old, load new, data_valid stays 1, no overrun.
  - data_valid==1 and data_ready==0: overrun pulse, new word dropped, old data kept.
- data_valid clears on the edge where data_valid&data_ready with no simultaneous delivery.
- Latency: rx falling edge to data_valid = 2 sync cycles + (DATA_BITS+1.5) bit times ±1 tick + 1 clk.
- frame_err and overrun are never asserted together.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even).
  - Adds the PARITY state, one bit between data and stop.
  - Adds output parity_err: one-cycle pulse, coincident with delivery, when the received parity mismatches. The word is still delivered.
- Undefined: no PARITY state, no parity_err port; frame is start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP.
  - Function calc_div(clk_hz, baud, os).
  - Constant UART_IDLE_LEVEL=1'b1.
- Sub-module uart_baud_tick (params DIV; ports clk, reset, restart, tick). It is reused by the planned parametrised transmitter.

Test Plan:
Bench uses CLK_HZ=16000000, BAUD=1000000, OVERSAMPLE=16 (DIV=1, 16 clk/bit).
1. Send frame 0x55, data_ready=1 → data_valid pulses 1 clk with data=0x55; frame_err=0; busy high ~152 clk.
2. rx low pulse of 4 clk then high → FSM returns to IDLE; no data_valid, no frame_err.
3. Send 0xA3 with stop bit forced 0 → frame_err 1-cycle pulse; data_valid stays 0; the next valid 0x3C frame is received correctly.
4. data_ready=0; send 0x11 then 0x22 back-to-back → data=0x11 held; overrun pulses at 0x22 completion; after data_ready=1, data_valid drops.
5. Pulse reset at data bit 4 of 0xF0 → all outputs 0 immediately; following frame 0x0F received intact.
6. With UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 0 → parity_err=1, data=0x07; repeat with parity bit 1 → parity_err=0.
